// File: rtl/pa_operand_feeder.sv
// Operand feeder: buffers host vector pairs in a FIFO and streams whole tiles of
// TILE_K pairs onto the array's v/h buses. Optional fill_level_o under PA_FEEDER_LEVEL_EN.
module pa_operand_feeder #(
   parameter int SIZE_MAT   = 16,
   parameter int WIDTH_DATA = 16,
   parameter int DEPTH      = 64,
   parameter int TILE_K     = 64
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               wr_valid_i,
   output logic                               wr_ready_o,
   input  logic [SIZE_MAT*WIDTH_DATA-1:0]     wr_v_i,
   input  logic [SIZE_MAT*WIDTH_DATA-1:0]     wr_h_i,
   input  logic                               read_en_i,
   output logic                               data_rdy_o,
   output logic [SIZE_MAT*WIDTH_DATA-1:0]     v_bus_o,
   output logic [SIZE_MAT*WIDTH_DATA-1:0]     h_bus_o,
   output logic                               underflow_o,
`ifdef PA_FEEDER_LEVEL_EN
   output logic [$clog2(DEPTH):0]             fill_level_o,
`endif
   output logic                               tile_done_o
);

   localparam int BW = SIZE_MAT*WIDTH_DATA;
   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(TILE_K);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [AW:0] TILE_C  = (AW+1)'(TILE_K);
   localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};
   localparam logic [TW:0] TILE_T  = (TW+1)'(TILE_K);
   localparam logic [TW:0] T_ONE   = {{TW{1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, READY, STREAM} state_t;

   state_t          state_q, state_d;
   logic [AW:0]     wr_ptr_q, rd_ptr_q, count_q, count_d;
   logic [TW:0]     tcnt_q, tcnt_d;
   logic [BW-1:0]   v_q, h_q;
   logic            under_q, done_q, done_d;
   logic            push, pop, under_set, tile_end;
   logic [AW:0]     post_cnt;
   logic [2*BW-1:0] mem_q [DEPTH];

   // Ready comes from the registered count only, so a same-cycle pop never frees a slot.
   assign wr_ready_o = (count_q < DEPTH_C);
   assign push       = wr_valid_i && wr_ready_o;

   always_comb begin
      state_d   = state_q;
      tcnt_d    = tcnt_q;
      pop       = 1'b0;
      under_set = 1'b0;
      tile_end  = 1'b0;
      done_d    = 1'b0;
      post_cnt  = push ? count_q : count_q - CNT_ONE;
      case (state_q)
         IDLE: begin
            if (read_en_i) under_set = 1'b1;
            if (count_q >= TILE_C) state_d = READY;
         end
         READY: begin
            if (read_en_i) begin
               pop      = 1'b1;
               tcnt_d   = T_ONE;
               state_d  = STREAM;
               tile_end = (T_ONE == TILE_T);
            end
         end
         STREAM: begin
            if (read_en_i) begin
               if (count_q != '0) begin
                  pop      = 1'b1;
                  tcnt_d   = tcnt_q + T_ONE;
                  tile_end = ((tcnt_q + T_ONE) == TILE_T);
               end else begin
                  under_set = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // Tile boundary: re-arm immediately if the next tile is already buffered.
      if (tile_end) begin
         done_d  = 1'b1;
         state_d = (post_cnt >= TILE_C) ? READY : IDLE;
      end
   end

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         tcnt_q   <= '0;
         v_q      <= '0;
         h_q      <= '0;
         under_q  <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         tcnt_q  <= tcnt_d;
         done_q  <= done_d;
         if (under_set) under_q <= 1'b1;
         if (push) wr_ptr_q <= wr_ptr_q + CNT_ONE;
         if (pop) begin
            rd_ptr_q   <= rd_ptr_q + CNT_ONE;
            {v_q, h_q} <= mem_q[rd_ptr_q[AW-1:0]];
         end
      end
   end

   // Storage needs no reset; a reset only rewinds the pointers.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= {wr_v_i, wr_h_i};
   end

   assign data_rdy_o  = (state_q == READY);
   assign v_bus_o     = v_q;
   assign h_bus_o     = h_q;
   assign underflow_o = under_q;
   assign tile_done_o = done_q;
`ifdef PA_FEEDER_LEVEL_EN
   assign fill_level_o = count_q;
`endif

endmodule

// File: tb/tb_pa_operand_feeder.sv
// Self-checking bench for pa_operand_feeder: queue-based reference model, directed
// scenarios followed by a randomized phase.
module tb_pa_operand_feeder;
   localparam int SM = 2, WD = 16, DP = 8, TK = 4, BW = SM*WD;

   logic clk = 1'b0, rst_n = 1'b1;
   logic wr_valid_i = 1'b0, read_en_i = 1'b0;
   logic [BW-1:0] wr_v_i = '0, wr_h_i = '0;
   logic wr_ready_o, data_rdy_o, underflow_o, tile_done_o;
   logic [BW-1:0] v_bus_o, h_bus_o;
`ifdef PA_FEEDER_LEVEL_EN
   logic [$clog2(DP):0] fill_level_o;
`endif

   pa_operand_feeder #(.SIZE_MAT(SM), .WIDTH_DATA(WD), .DEPTH(DP), .TILE_K(TK)) dut (
      .clk(clk), .rst_n(rst_n), .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
      .wr_v_i(wr_v_i), .wr_h_i(wr_h_i), .read_en_i(read_en_i), .data_rdy_o(data_rdy_o),
      .v_bus_o(v_bus_o), .h_bus_o(h_bus_o), .underflow_o(underflow_o),
`ifdef PA_FEEDER_LEVEL_EN
      .fill_level_o(fill_level_o),
`endif
      .tile_done_o(tile_done_o));

   always #5 clk = ~clk;

   int nchk = 0, nerr = 0;

   // Reference model: a queue of pairs plus a mode (0 waiting, 1 tile available, 2 streaming).
   logic [BW-1:0] mq_v[$], mq_h[$];
   int m_mode, m_tcnt;
   logic [BW-1:0] m_v, m_h;
   logic m_under, m_done;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".wr_ready"}, 64'(wr_ready_o), 64'(mq_v.size() < DP));
      chk({tag, ".data_rdy"}, 64'(data_rdy_o), 64'(m_mode == 1));
      chk({tag, ".v_bus"}, 64'(v_bus_o), 64'(m_v));
      chk({tag, ".h_bus"}, 64'(h_bus_o), 64'(m_h));
      chk({tag, ".underflow"}, 64'(underflow_o), 64'(m_under));
      chk({tag, ".tile_done"}, 64'(tile_done_o), 64'(m_done));
`ifdef PA_FEEDER_LEVEL_EN
      chk({tag, ".fill_level"}, 64'(fill_level_o), 64'(mq_v.size()));
`endif
   endtask

   task automatic mreset();
      mq_v.delete(); mq_h.delete();
      m_mode = 0; m_tcnt = 0; m_v = '0; m_h = '0; m_under = 1'b0; m_done = 1'b0;
   endtask

   task automatic step(input string tag, input logic wv, input logic re,
                       input logic [BW-1:0] dv, input logic [BW-1:0] dh);
      int  sz;
      bit  acc, popped;
      wr_valid_i = wv; read_en_i = re; wr_v_i = dv; wr_h_i = dh;
      @(posedge clk);
      sz = mq_v.size();
      acc = wv && (sz < DP);
      popped = 1'b0;
      m_done = 1'b0;
      case (m_mode)
         0: begin
            if (re) m_under = 1'b1;
            if (sz >= TK) m_mode = 1;
         end
         1: if (re) begin popped = 1'b1; m_tcnt = 1; m_mode = 2; end
         default: if (re) begin
            if (sz != 0) begin popped = 1'b1; m_tcnt++; end
            else m_under = 1'b1;
         end
      endcase
      if (popped) begin
         m_v = mq_v.pop_front();
         m_h = mq_h.pop_front();
      end
      if (acc) begin mq_v.push_back(dv); mq_h.push_back(dh); end
      if (popped && m_tcnt == TK) begin
         m_done = 1'b1;
         m_mode = (mq_v.size() >= TK) ? 1 : 0;
      end
      #1 check_all(tag);
   endtask

   function automatic logic [BW-1:0] rnd();
      return BW'($urandom);
   endfunction

   function automatic logic [BW-1:0] rep(input int i);
      return {SM{WD'(i)}};
   endfunction

   // Asynchronous reset asserted between clock edges.
   task automatic areset(input string tag);
      #2 rst_n = 1'b0;
      wr_valid_i = 1'b0; read_en_i = 1'b0;
      #1 mreset();
      check_all(tag);
      @(negedge clk) rst_n = 1'b1;
   endtask

   initial begin
      mreset();
      #1 rst_n = 1'b0;
      #10 check_all("reset");
      @(negedge clk) rst_n = 1'b1;

      // basic tile
      for (int i = 1; i <= 4; i++) step("basic_push", 1, 0, rep(i), rnd());
      repeat (2) step("basic_wait", 0, 0, rnd(), rnd());
      chk("basic_rdy", 64'(data_rdy_o), 64'(1));
      for (int i = 1; i <= 4; i++) begin
         step("basic_read", 0, 1, rnd(), rnd());
         chk("basic_vword", 64'(v_bus_o), 64'(rep(i)));
      end
      chk("basic_done", 64'(tile_done_o), 64'(1));
      repeat (2) step("basic_idle", 0, 0, rnd(), rnd());

      // back-to-back tiles
      for (int i = 1; i <= 8; i++) step("b2b_push", 1, 0, rep(i + 16), rnd());
      repeat (2) step("b2b_wait", 0, 0, rnd(), rnd());
      for (int i = 1; i <= 8; i++) step("b2b_read", 0, 1, rnd(), rnd());
      step("b2b_idle", 0, 0, rnd(), rnd());

      // full FIFO: 9th pair held until the cycle after a pop
      for (int i = 1; i <= 9; i++) step("full_push", 1, 0, rnd(), rnd());
      chk("full_ready", 64'(wr_ready_o), 64'(0));
      step("full_wait", 1, 0, wr_v_i, wr_h_i);
      step("full_pop", 1, 1, wr_v_i, wr_h_i);
      step("full_accept", 1, 0, wr_v_i, wr_h_i);
      repeat (7) step("full_drain", 0, 1, rnd(), rnd());
      areset("full_rst");

      // stall inside a stream
      for (int i = 1; i <= 4; i++) step("stall_push", 1, 0, rep(i), rnd());
      repeat (2) step("stall_wait", 0, 0, rnd(), rnd());
      begin
         logic [5:0] pat;
         pat = 6'b111001;
         for (int i = 0; i < 6; i++) step("stall_read", 0, pat[i], rnd(), rnd());
      end
      chk("stall_under", 64'(underflow_o), 64'(0));
      areset("stall_rst");

      // underflow in IDLE, push accepted alongside an underflowing read
      for (int i = 0; i < 2; i++) step("uf_push", 1, 0, rnd(), rnd());
      step("uf_read", 0, 1, rnd(), rnd());
      chk("uf_sticky", 64'(underflow_o), 64'(1));
      step("uf_push_read", 1, 1, rnd(), rnd());
      repeat (2) step("uf_idle", 0, 0, rnd(), rnd());
      areset("uf_rst");
      for (int i = 0; i < 4; i++) step("mid_push", 1, 0, rnd(), rnd());
      repeat (2) step("mid_wait", 0, 0, rnd(), rnd());
      repeat (2) step("mid_read", 0, 1, rnd(), rnd());
      areset("mid_rst");

      // pointer wrap with simultaneous push and pop
      for (int i = 0; i < 4; i++) step("wrap_fill", 1, 0, rnd(), rnd());
      repeat (2) step("wrap_wait", 0, 0, rnd(), rnd());
      for (int i = 0; i < 20; i++) step("wrap_pp", 1, 1, rnd(), rnd());
      repeat (4) step("wrap_drain", 0, 1, rnd(), rnd());
      areset("wrap_rst");

      // randomized traffic
      for (int i = 0; i < 400; i++)
         step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), rnd(), rnd());

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end
endmodule
